// File: rtl/pipelined_alu.sv
// pipelined_alu: registered execute-stage ALU with valid/ready handshakes on both sides.
// Define PIPELINED_ALU_MULDIV_EN to add the iterative unsigned MUL/MULHU/DIVU/REMU unit.
module pipelined_alu #(
    parameter int WordSize = 32,
    parameter int TagWidth = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WordSize-1:0] in_a,
    input  logic [WordSize-1:0] in_b,
    input  logic [5:0]          in_mode,
    input  logic [TagWidth-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WordSize-1:0] out_result,
    output logic                out_zero,
    output logic [TagWidth-1:0] out_tag
);
    localparam int ShiftW = $clog2(WordSize);

    logic [ShiftW-1:0]   shamt;
    logic [WordSize-1:0] alu_result;
    logic                accept;

    assign shamt  = in_b[ShiftW-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        alu_result = '0;
        case (in_mode)
            6'h00:   alu_result = in_a + in_b;
            6'h20:   alu_result = in_a - in_b;
            6'h04:   alu_result = in_a ^ in_b;
            6'h06:   alu_result = in_a | in_b;
            6'h07:   alu_result = in_a & in_b;
            6'h01:   alu_result = in_a << shamt;
            6'h05:   alu_result = in_a >> shamt;
            6'h25:   alu_result = $signed(in_a) >>> shamt;
            6'h02:   alu_result = {{(WordSize-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            6'h03:   alu_result = {{(WordSize-1){1'b0}}, (in_a < in_b)};
            default: alu_result = '0;
        endcase
    end

`ifdef PIPELINED_ALU_MULDIV_EN
    localparam int CntW = $clog2(WordSize + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [CntW-1:0]       cnt;
    logic [WordSize-1:0]   operand;
    logic [2*WordSize-1:0] prod;
    logic [2*WordSize-1:0] step_prod;
    logic                  is_div;
    logic                  want_high;
    logic                  is_muldiv_in;
    logic [WordSize:0]     mul_sum;
    logic [WordSize:0]     div_trial;
    logic [WordSize-1:0]   md_result;

    assign is_muldiv_in = (in_mode == 6'h08) || (in_mode == 6'h0B) ||
                          (in_mode == 6'h0D) || (in_mode == 6'h0F);
    assign in_ready     = (state == IDLE) && (!out_valid || out_ready);

    // prod holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide;
    // a zero divisor naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WordSize-1:WordSize]} + (prod[0] ? {1'b0, operand} : '0);
        div_trial = {prod[2*WordSize-1:WordSize], prod[WordSize-1]} - {1'b0, operand};
        if (!is_div)
            step_prod = {mul_sum, prod[WordSize-1:1]};
        else if (!div_trial[WordSize])
            step_prod = {div_trial[WordSize-1:0], prod[WordSize-2:0], 1'b1};
        else
            step_prod = {prod[2*WordSize-2:0], 1'b0};
        md_result = want_high ? step_prod[2*WordSize-1:WordSize] : step_prod[WordSize-1:0];
    end
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_tag    <= '0;
`ifdef PIPELINED_ALU_MULDIV_EN
            state      <= IDLE;
            cnt        <= '0;
            operand    <= '0;
            prod       <= '0;
            is_div     <= 1'b0;
            want_high  <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
`ifdef PIPELINED_ALU_MULDIV_EN
            if (state == BUSY) begin
                prod <= step_prod;
                cnt  <= cnt - 1'b1;
                if (cnt == CntW'(1)) begin
                    out_result <= md_result;
                    out_zero   <= (md_result == '0);
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                end
            end else if (accept && is_muldiv_in) begin
                operand   <= in_mode[2] ? in_b : in_a;
                prod      <= {{WordSize{1'b0}}, (in_mode[2] ? in_a : in_b)};
                is_div    <= in_mode[2];
                want_high <= in_mode[1];
                out_tag   <= in_tag;
                cnt       <= CntW'(WordSize);
                state     <= BUSY;
            end else
`endif
            if (accept) begin
                out_result <= alu_result;
                out_zero   <= (alu_result == '0);
                out_tag    <= in_tag;
                out_valid  <= 1'b1;
            end
        end
    end
endmodule
